xbar_config_loader: RTL and testbench
=====================================

// Module: xbar_config_loader
// PURPOSE
//  Loads crossbar select configuration word-by-word over a valid/ready port into a shadow register.
//  On commit, range-checks every select field and, if all pass, copies shadow to active.
//  Active register drives io_mux_configs of the downstream xbar (field i = bits [i*SEL_W +: SEL_W] -> io_xbar_out[i]).
//  Sits directly upstream of xbar inside the LUT tile.
// PARAMETERS
//  NUM_IN    35   xbar input count; legal select values 0..NUM_IN-1
//  NUM_OUT   48   xbar output count = number of select fields
//  SEL_W     6    bits per select field; must satisfy 2**SEL_W >= NUM_IN
//  WORD_W    32   config load word width
//  CFG_W     NUM_OUT*SEL_W (288)            derived: total config bits
//  NUM_WORDS (CFG_W+WORD_W-1)/WORD_W (9)    derived: words per full load
// PORTS
//  clk              in   1      clock
//  reset            in   1      asynchronous, active-high reset
//  io_cfg_valid     in   1      load word valid
//  io_cfg_ready     out  1      loader can accept a word
//  io_cfg_data      in   WORD_W load word; word k fills shadow[k*WORD_W +: WORD_W]
//  io_commit        in   1      single-cycle request to validate and apply shadow
//  io_abort         in   1      discard partial load, return to IDLE
//  io_cfg_done      out  1      1-cycle pulse: commit succeeded, active updated
//  io_cfg_err       out  1      sticky: last commit rejected (bad field or commit before FULL)
//  io_err_field     out  SEL_W+1  index of lowest offending field (NUM_OUT = premature commit)
//  io_active_valid  out  1      at least one successful commit since reset
//  io_mux_configs   out  CFG_W  active configuration to xbar
// BEHAVIOUR
//  Reset (async): state=IDLE, word_cnt=0, shadow=0, active=0 (all outputs select input 0),
//   io_cfg_ready=0, io_cfg_done=0, io_cfg_err=0, io_err_field=0, io_active_valid=0.
//   All outputs are registered; io_cfg_ready rises the first clock edge after reset deasserts.
//  Accept: word taken when io_cfg_valid && io_cfg_ready && !io_abort. Bits of the final word
//   above CFG_W are ignored. Accepting any word clears io_cfg_err.
//  FSM:
//   IDLE : ready=1; accepted word -> shadow word 0, word_cnt=1, -> LOAD (-> FULL if NUM_WORDS==1)
//   LOAD : ready=1; accepted word -> shadow word word_cnt, word_cnt++; word NUM_WORDS-1 -> FULL
//   FULL : ready=0; waits for io_commit
//   io_commit in FULL: all fields < NUM_IN -> active<=shadow, io_cfg_done=1 next cycle,
//     io_active_valid=1; else active unchanged, io_cfg_err=1, io_err_field=lowest bad index.
//     Either outcome -> IDLE, word_cnt=0.
//   io_commit in IDLE/LOAD: no load change; io_cfg_err=1, io_err_field=NUM_OUT; state held.
//  Latency: commit at edge N -> io_mux_configs/io_cfg_done/io_cfg_err valid after edge N (1 cycle).
//  io_abort: any state -> IDLE, word_cnt=0, active untouched; abort beats commit and a
//   coincident handshake (that word is dropped). Commit coincident with the last word: ignored
//   as premature (state not yet FULL), flags error.
//  io_mux_configs changes only on successful commit or reset; never glitches during loading.
//  Reset mid-load: partial shadow discarded, active returns to 0.
// STRUCTURE
//  Package xbar_cfg_pkg: SEL_W, NUM_IN, NUM_OUT, WORD_W, CFG_W, NUM_WORDS, state enum
//   {IDLE, LOAD, FULL}.
//  Sub-module xbar_sel_check: combinational; shadow in -> all_ok, lowest bad field index out
//   (priority encoder over NUM_OUT comparators).
//  Top: FSM, word counter ($clog2(NUM_WORDS+1) bits), shadow and active registers, output regs.
// TESTING
//  1 Reset then load 9 words with field i = i%35, commit -> io_cfg_done pulse 1 cycle later,
//    io_mux_configs[5:0]=0, [209:204]=34, [215:210]=0, io_active_valid=1.
//  2 Full load with field 7 = 35 and field 20 = 63, commit -> io_cfg_err=1, io_err_field=7,
//    io_mux_configs unchanged from test 1; next accepted word clears io_cfg_err.
//  3 Load 4 words, assert io_abort together with valid -> word dropped, state IDLE; fresh
//    9-word load + commit succeeds with new data.
//  4 io_commit after 5 words -> io_cfg_err=1, io_err_field=48, load continues; 4 more words
//    + commit -> success.
//  5 Random io_cfg_valid gaps and ready checks: ready=0 in FULL, no word lost/duplicated;
//    compare io_mux_configs vs reference model over 1000 loads.
//  6 Assert reset asynchronously mid-load (between edges) -> outputs go to reset values
//    immediately; ready=0 until first edge after release.

Source files
------------

// File: rtl/xbar_config_loader_pkg.sv
// Shared constants and state encoding for the crossbar configuration loader.
// Field i of the configuration drives xbar output i.
package xbar_cfg_pkg;

   localparam int unsigned NUM_IN    = 35;
   localparam int unsigned NUM_OUT   = 48;
   localparam int unsigned SEL_W     = 6;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned CFG_W     = NUM_OUT * SEL_W;
   localparam int unsigned NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
   localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
   localparam int unsigned PAD_W     = NUM_WORDS * WORD_W;
   localparam int unsigned FIELD_W   = SEL_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FULL
   } state_t;

endpackage

// File: rtl/xbar_config_loader_sel_check.sv
// Range check of every select field in the shadow configuration.
// Reports whether all fields are legal and the index of the lowest illegal one.
module xbar_sel_check
   import xbar_cfg_pkg::*;
(
   input  logic [CFG_W-1:0]   shadow,
   output logic               all_ok,
   output logic [SEL_W:0]     bad_field
);

   // Scan from the top down so the last hit recorded is the lowest index.
   always_comb begin
      all_ok    = 1'b1;
      bad_field = '0;
      for (int unsigned i = NUM_OUT; i > 0; i--) begin
         if (32'(shadow[(i-1)*SEL_W +: SEL_W]) >= NUM_IN) begin
            all_ok    = 1'b0;
            bad_field = FIELD_W'(i - 1);
         end
      end
   end

endmodule

// File: rtl/xbar_config_loader.sv
// Loads crossbar select words into a shadow register and, on a validated
// commit, transfers them to the active configuration driving the xbar.
module xbar_config_loader
   import xbar_cfg_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                io_cfg_valid,
   output logic                io_cfg_ready,
   input  logic [WORD_W-1:0]   io_cfg_data,
   input  logic                io_commit,
   input  logic                io_abort,
   output logic                io_cfg_done,
   output logic                io_cfg_err,
   output logic [SEL_W:0]      io_err_field,
   output logic                io_active_valid,
   output logic [CFG_W-1:0]    io_mux_configs
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PAD_W-1:0]    shadow_q;
   logic                accept;
   logic                commit_req;
   logic                commit_ok;
   logic                commit_bad;
   logic [SEL_W:0]      bad_idx_d;
   logic                all_ok;
   logic [SEL_W:0]      bad_field;

   xbar_sel_check u_sel_check (
      .shadow    (shadow_q[CFG_W-1:0]),
      .all_ok    (all_ok),
      .bad_field (bad_field)
   );

   // Abort overrides both a coincident handshake and a coincident commit.
   assign accept     = io_cfg_valid && io_cfg_ready && !io_abort;
   assign commit_req = io_commit && !io_abort;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      commit_ok  = 1'b0;
      commit_bad = 1'b0;
      bad_idx_d  = '0;
      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == CNT_W'(NUM_WORDS - 1)) ? FULL : LOAD;
            end
            if (commit_req) begin
               commit_bad = 1'b1;
               bad_idx_d  = FIELD_W'(NUM_OUT);
            end
         end
         FULL: begin
            if (commit_req) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (all_ok) begin
                  commit_ok = 1'b1;
               end else begin
                  commit_bad = 1'b1;
                  bad_idx_d  = bad_field;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (io_abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         shadow_q        <= '0;
         io_mux_configs  <= '0;
         io_cfg_ready    <= 1'b0;
         io_cfg_done     <= 1'b0;
         io_cfg_err      <= 1'b0;
         io_err_field    <= '0;
         io_active_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         io_cfg_ready <= (state_d != FULL);
         io_cfg_done  <= commit_ok;
         if (accept) begin
            shadow_q[32'(cnt_q)*WORD_W +: WORD_W] <= io_cfg_data;
         end
         if (commit_ok) begin
            io_mux_configs  <= shadow_q[CFG_W-1:0];
            io_active_valid <= 1'b1;
         end
         // A rejected commit wins over a word accepted in the same cycle.
         if (commit_bad) begin
            io_cfg_err   <= 1'b1;
            io_err_field <= bad_idx_d;
         end else if (commit_ok || accept) begin
            io_cfg_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xbar_config_loader.sv
// Self-checking bench for xbar_config_loader: directed scenarios followed by
// randomized loads compared against a field-level reference model.
module tb_xbar_config_loader;
   import xbar_cfg_pkg::*;

   logic                clk;
   logic                reset;
   logic                io_cfg_valid;
   logic                io_cfg_ready;
   logic [WORD_W-1:0]   io_cfg_data;
   logic                io_commit;
   logic                io_abort;
   logic                io_cfg_done;
   logic                io_cfg_err;
   logic [SEL_W:0]      io_err_field;
   logic                io_active_valid;
   logic [CFG_W-1:0]    io_mux_configs;

   xbar_config_loader dut (
      .clk             (clk),
      .reset           (reset),
      .io_cfg_valid    (io_cfg_valid),
      .io_cfg_ready    (io_cfg_ready),
      .io_cfg_data     (io_cfg_data),
      .io_commit       (io_commit),
      .io_abort        (io_abort),
      .io_cfg_done     (io_cfg_done),
      .io_cfg_err      (io_cfg_err),
      .io_err_field    (io_err_field),
      .io_active_valid (io_active_valid),
      .io_mux_configs  (io_mux_configs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: words loaded so far, shadow/active images, flags.
   logic [PAD_W-1:0]  m_shadow;
   logic [CFG_W-1:0]  m_active;
   int                m_cnt;
   bit                m_err;
   int                m_field;
   bit                m_valid;
   bit                m_done;
   bit                m_ready_en;
   int                fld [NUM_OUT];

   task automatic chk(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/ready"}, CFG_W'(io_cfg_ready), CFG_W'(m_ready_en && (m_cnt != NUM_WORDS)));
      chk({tag, "/done"}, CFG_W'(io_cfg_done), CFG_W'(m_done));
      chk({tag, "/err"}, CFG_W'(io_cfg_err), CFG_W'(m_err));
      chk({tag, "/err_field"}, CFG_W'(io_err_field), CFG_W'(m_field));
      chk({tag, "/active_valid"}, CFG_W'(io_active_valid), CFG_W'(m_valid));
      chk({tag, "/mux"}, io_mux_configs, m_active);
   endtask

   task automatic model_reset();
      m_shadow   = '0;
      m_active   = '0;
      m_cnt      = 0;
      m_err      = 1'b0;
      m_field    = 0;
      m_valid    = 1'b0;
      m_done     = 1'b0;
      m_ready_en = 1'b0;
   endtask

   task automatic model_commit();
      int bad;
      m_done = 1'b0;
      if (m_cnt == NUM_WORDS) begin
         bad = -1;
         for (int i = 0; i < NUM_OUT; i++)
            if (bad < 0 && int'(m_shadow[i*SEL_W +: SEL_W]) >= NUM_IN) bad = i;
         if (bad < 0) begin
            m_active = m_shadow[CFG_W-1:0];
            m_valid  = 1'b1;
            m_done   = 1'b1;
            m_err    = 1'b0;
         end else begin
            m_err   = 1'b1;
            m_field = bad;
         end
         m_cnt = 0;
      end else begin
         m_err   = 1'b1;
         m_field = NUM_OUT;
      end
   endtask

   function automatic logic [PAD_W-1:0] build_vec();
      logic [PAD_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_OUT; i++) v[i*SEL_W +: SEL_W] = SEL_W'(fld[i]);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w);
      int n;
      io_cfg_valid = 1'b1;
      io_cfg_data  = w;
      n = 0;
      while (io_cfg_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("ready_wait", CFG_W'(io_cfg_ready), CFG_W'(1));
      step();
      io_cfg_valid = 1'b0;
      if (m_cnt < NUM_WORDS) begin
         m_shadow[m_cnt*WORD_W +: WORD_W] = w;
         m_cnt++;
         m_err = 1'b0;
      end
      m_done = 1'b0;
   endtask

   task automatic send_words(input int first, input int last, input int gap_max);
      logic [PAD_W-1:0] v;
      v = build_vec();
      for (int k = first; k <= last; k++) begin
         if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) step();
         send_word(v[k*WORD_W +: WORD_W]);
      end
   endtask

   task automatic do_commit(input string tag);
      io_commit = 1'b1;
      step();
      io_commit = 1'b0;
      model_commit();
      check_all(tag);
      step();
      m_done = 1'b0;
      check_all({tag, "_after"});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      io_cfg_valid = 1'b0;
      io_cfg_data  = '0;
      io_commit    = 1'b0;
      io_abort     = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ready_before_edge", CFG_W'(io_cfg_ready), CFG_W'(0));
      step();
      m_ready_en = 1'b1;
      check_all("first_edge");

      // Test 1: field i = i % NUM_IN
      for (int i = 0; i < NUM_OUT; i++) fld[i] = i % NUM_IN;
      send_words(0, NUM_WORDS - 1, 0);
      check_all("t1_full");
      do_commit("t1_commit");
      chk("t1_f0", CFG_W'(io_mux_configs[5:0]), CFG_W'(0));
      chk("t1_f34", CFG_W'(io_mux_configs[209:204]), CFG_W'(34));
      chk("t1_f35", CFG_W'(io_mux_configs[215:210]), CFG_W'(0));

      // Test 2: illegal fields 7 and 20
      fld[7]  = 35;
      fld[20] = 63;
      send_words(0, NUM_WORDS - 1, 0);
      do_commit("t2_commit");
      chk("t2_err_field", CFG_W'(io_err_field), CFG_W'(7));
      send_words(0, 0, 0);
      check_all("t2_clear");

      // Test 3: abort with a coincident word, then a clean reload
      io_abort = 1'b1;
      step();
      io_abort = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < NUM_OUT; i++) fld[i] = (i * 7 + 3) % NUM_IN;
      send_words(0, 3, 0);
      io_cfg_valid = 1'b1;
      io_abort     = 1'b1;
      io_cfg_data  = 32'hDEAD_BEEF;
      step();
      io_cfg_valid = 1'b0;
      io_abort     = 1'b0;
      m_cnt = 0;
      check_all("t3_abort");
      send_words(0, NUM_WORDS - 1, 0);
      do_commit("t3_commit");

      // Test 4: premature commit after 5 words
      for (int i = 0; i < NUM_OUT; i++) fld[i] = NUM_IN - 1 - (i % NUM_IN);
      send_words(0, 4, 0);
      do_commit("t4_early");
      chk("t4_err_field", CFG_W'(io_err_field), CFG_W'(NUM_OUT));
      send_words(5, NUM_WORDS - 1, 0);
      do_commit("t4_commit");

      // Test 5: randomized loads with gaps
      for (int l = 0; l < 1000; l++) begin
         for (int i = 0; i < NUM_OUT; i++) fld[i] = $urandom_range(NUM_IN - 1, 0);
         if ($urandom_range(3, 0) == 0) fld[$urandom_range(NUM_OUT - 1, 0)] = $urandom_range(63, NUM_IN);
         if ($urandom_range(7, 0) == 0) begin
            send_words(0, $urandom_range(NUM_WORDS - 2, 0), 2);
            do_commit("r_early");
            m_cnt = 0;
            io_abort = 1'b1;
            step();
            io_abort = 1'b0;
         end
         send_words(0, NUM_WORDS - 1, 2);
         io_cfg_valid = 1'b1;
         io_cfg_data  = $urandom;
         step();
         io_cfg_valid = 1'b0;
         check_all("r_full_blocked");
         do_commit("r_commit");
      end

      // Test 6: asynchronous reset mid-load
      send_words(0, 3, 0);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("t6_async");
      #2;
      reset = 1'b0;
      #1;
      chk("t6_ready_low", CFG_W'(io_cfg_ready), CFG_W'(0));
      step();
      m_ready_en = 1'b1;
      check_all("t6_released");
      for (int i = 0; i < NUM_OUT; i++) fld[i] = (i * 11) % NUM_IN;
      send_words(0, NUM_WORDS - 1, 1);
      do_commit("t6_commit");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
